core_trap_unit: RTL

CORE_TRAP_UNIT -- requirements
Module: core_trap_unit

---
 rtl/core_trap_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/core_trap_unit.sv
// core_trap_unit: pending-interrupt tracking, M/S priority arbitration and trap capture FSM
package core_pkg;
   typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} priv_e;
   typedef enum logic [4:0] {
      EXC_INSN_MISALIGN  = 5'd0,
      EXC_INSN_FAULT     = 5'd1,
      EXC_ILLEGAL_INSN   = 5'd2,
      EXC_BREAKPOINT     = 5'd3,
      EXC_LOAD_MISALIGN  = 5'd4,
      EXC_LOAD_FAULT     = 5'd5,
      EXC_STORE_MISALIGN = 5'd6,
      EXC_STORE_FAULT    = 5'd7,
      EXC_ECALL_U        = 5'd8,
      EXC_ECALL_S        = 5'd9,
      EXC_ECALL_M        = 5'd11,
      EXC_INSN_PAGE      = 5'd12,
      EXC_LOAD_PAGE      = 5'd13,
      EXC_STORE_PAGE     = 5'd15
   } exception_e;
endpackage

module core_trap_unit #(
   parameter int NUM_INT = 16,
   parameter logic [NUM_INT-1:0] EDGE_MASK = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_INT-1:0]    int_src,
   input  logic [NUM_INT-1:0]    int_enable,
   input  logic [NUM_INT-1:0]    int_deleg,
   input  core_pkg::priv_e       priv,
   input  logic                  cfg_mie,
   input  logic                  cfg_sie,
   input  logic                  check_interrupt,
   input  logic                  ex_valid,
   input  core_pkg::exception_e  ex_cause,
   input  logic [31:0]           ex_value,
   input  logic [NUM_INT-1:0]    pending_clr,
   input  logic                  trap_ack,
   output logic                  trap_valid,
   output logic                  trap_is_int,
   output logic                  trap_to_s,
   output logic [4:0]            trap_cause,
   output logic [31:0]           trap_value,
   output logic [NUM_INT-1:0]    pending
);
   typedef enum logic {IDLE, TRAP} state_e;
   state_e               state_q, state_d;
   logic [NUM_INT-1:0]   src_q, pend_q, pend_d;
   logic                 is_int_q, is_int_d, to_s_q, to_s_d;
   logic [4:0]           cause_q, cause_d;
   logic [31:0]          value_q, value_d;
   logic                 m_en, s_en, ack_int;
   logic [NUM_INT-1:0]   m_act, s_act, sel, auto_clr;
   logic [4:0]           idx;

   always_comb begin
      m_en = (priv == core_pkg::PRIV_M) ? cfg_mie : 1'b1;
      s_en = (priv == core_pkg::PRIV_M) ? 1'b0 : (priv == core_pkg::PRIV_S) ? cfg_sie : 1'b1;
      m_act = pend_q & int_enable & ~int_deleg & {NUM_INT{m_en}};
      s_act = pend_q & int_enable & int_deleg & {NUM_INT{s_en}};
      sel = (|m_act) ? m_act : s_act;
      ack_int = (state_q == TRAP) && trap_ack && is_int_q;
      idx = '0;
      auto_clr = '0;
      for (int i = 0; i < NUM_INT; i++) begin
         if (sel[i]) idx = 5'(i);
         auto_clr[i] = ack_int && (cause_q == 5'(i));
      end
      // a new rising edge beats any clear arriving in the same cycle
      pend_d = (EDGE_MASK & ((int_src & ~src_q) | (pend_q & ~(pending_clr | auto_clr))))
             | (~EDGE_MASK & int_src);
      state_d  = state_q;
      is_int_d = is_int_q;
      to_s_d   = to_s_q;
      cause_d  = cause_q;
      value_d  = value_q;
      if (state_q == IDLE) begin
         if (ex_valid) begin
            state_d  = TRAP;
            is_int_d = 1'b0;
            to_s_d   = 1'b0;
            cause_d  = ex_cause;
            value_d  = ex_value;
         end else if (check_interrupt && |sel) begin
            state_d  = TRAP;
            is_int_d = 1'b1;
            to_s_d   = ~|m_act;
            cause_d  = idx;
            value_d  = '0;
         end
      end else if (trap_ack) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         src_q    <= '0;
         pend_q   <= '0;
         is_int_q <= 1'b0;
         to_s_q   <= 1'b0;
         cause_q  <= '0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= int_src;
         pend_q   <= pend_d;
         is_int_q <= is_int_d;
         to_s_q   <= to_s_d;
         cause_q  <= cause_d;
         value_q  <= value_d;
      end
   end

   assign trap_valid  = (state_q == TRAP);
   assign trap_is_int = is_int_q;
   assign trap_to_s   = to_s_q;
   assign trap_cause  = cause_q;
   assign trap_value  = value_q;
   assign pending     = pend_q;
endmodule
